line_burst_adapter: RTL and testbench

- Responder side of the cache-line request interface driven by the cache controller (ca_read / ca_write / ca_resp).
- Converts one 256-bit line read or writeback into a 4-beat 64-bit burst on the physical-memory port.
- Returns a single-cycle response to the controller once the whole line has transferred.
- Sits between each cache instance and the memory arbiter / physical memory.

---
 rtl/line_burst_adapter.sv | 99 +++++++++
 tb/tb_line_burst_adapter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/line_burst_adapter.sv
// Turns one cache-line read or writeback into a burst of beat-sized memory transfers.
// When the whole line has moved, it sends the controller a single-cycle response.
module line_burst_adapter #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [s_line-1:0]    line_i,
  output logic [s_line-1:0]    line_o,
  input  logic [31:0]          address_i,
  input  logic                 read_i,
  input  logic                 write_i,
  output logic                 resp_o,
  input  logic [s_burst-1:0]   burst_i,
  output logic [s_burst-1:0]   burst_o,
  output logic [31:0]          address_o,
  output logic                 read_o,
  output logic                 write_o,
  input  logic                 resp_i
);

  localparam int n_beats = s_line / s_burst;
  localparam int cnt_w   = $clog2(n_beats);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(n_beats - 1);
  localparam logic [31:0] off_mask = (32'd1 << s_offset) - 32'd1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                               state;
  logic [cnt_w-1:0]                     cnt;
  logic [n_beats-1:0][s_burst-1:0]      line_buf;

  assign line_o  = line_buf;
  assign burst_o = line_buf[cnt];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      line_buf  <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A write wins when both requests are present.
          if (write_i) begin
            line_buf  <= line_i;
            address_o <= address_i & ~off_mask;
            cnt       <= '0;
            write_o   <= 1'b1;
            state     <= WRITE;
          end else if (read_i) begin
            address_o <= address_i & ~off_mask;
            cnt       <= '0;
            read_o    <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            line_buf[cnt] <= burst_i;
            cnt           <= cnt + cnt_w'(1);
            if (cnt == last_beat) begin
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt <= cnt + cnt_w'(1);
            if (cnt == last_beat) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          resp_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          read_o  <= 1'b0;
          write_o <= 1'b0;
          resp_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed and randomized checks of line_burst_adapter against a beat-level memory model.
module tb_line_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_burst_adapter dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One complete line transfer.
  // The memory side acknowledges each beat after a random stall drawn from gap_lo..gap_hi.
  // The call returns in the IDLE cycle that follows the response.
  task automatic txn(input bit wr, input bit both, input logic [31:0] addr,
                     input logic [255:0] wline, input logic [255:0] rline,
                     input int gap_lo, input int gap_hi);
    logic [31:0] exp_addr;
    bit          exp_wr;
    int          gap;
    exp_addr  = {addr[31:5], 5'b0};
    exp_wr    = wr || both;
    write_i   = wr || both;
    read_i    = !wr || both;
    address_i = addr;
    line_i    = wline;
    resp_i    = 1'b0;
    @(negedge clk);
    line_i    = rand_line();
    address_i = $urandom;
    for (int k = 0; k < 4; k++) begin
      gap = $urandom_range(gap_hi, gap_lo);
      for (int g = 0; g <= gap; g++) begin
        chk("read_o_busy", read_o, !exp_wr);
        chk("write_o_busy", write_o, exp_wr);
        chk("resp_o_busy", resp_o, 1'b0);
        chk("address_o", address_o, exp_addr);
        if (exp_wr) chk("burst_o", burst_o, wline[64*k +: 64]);
        resp_i  = (g == gap);
        burst_i = (g == gap) ? rline[64*k +: 64] : 64'($urandom);
        @(negedge clk);
      end
      resp_i = 1'b0;
    end
    chk("resp_o_done", resp_o, 1'b1);
    chk("read_o_done", read_o, 1'b0);
    chk("write_o_done", write_o, 1'b0);
    chk("line_o_done", line_o, exp_wr ? wline : rline);
    read_i  = 1'b0;
    write_i = 1'b0;
    @(negedge clk);
    chk("resp_o_idle", resp_o, 1'b0);
    chk("read_o_idle", read_o, 1'b0);
    chk("write_o_idle", write_o, 1'b0);
  endtask

  logic [255:0] rl, wl;

  initial begin
    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = 32'hFFFF_FFFF; line_i = '1; burst_i = '1;

    // Reset, then idle.
    repeat (2) begin
      @(negedge clk);
      chk("rst_read_o", read_o, 1'b0);
      chk("rst_write_o", write_o, 1'b0);
      chk("rst_resp_o", resp_o, 1'b0);
      chk("rst_line_o", line_o, '0);
      chk("rst_burst_o", burst_o, '0);
      chk("rst_address_o", address_o, '0);
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_read_o", read_o, 1'b0);
      chk("idle_write_o", write_o, 1'b0);
      chk("idle_resp_o", resp_o, 1'b0);
      chk("idle_line_o", line_o, '0);
    end

    // Back-to-back read, with an acknowledge every cycle.
    rl = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    txn(1'b0, 1'b0, 32'h0000_1234, '0, rl, 0, 0);
    chk("read_addr_1220", address_o, 32'h0000_1220);

    // Stalled write, with two idle cycles between acknowledges.
    wl = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    txn(1'b1, 1'b0, 32'h8000_00FF, wl, '0, 2, 2);

    // Writeback followed immediately by a load.
    wl = rand_line(); rl = rand_line();
    txn(1'b1, 1'b0, 32'h0000_4040, wl, '0, 0, 1);
    txn(1'b0, 1'b0, 32'h0000_4040, '0, rl, 0, 1);

    // Read and write requested together: the write is taken.
    wl = rand_line();
    txn(1'b1, 1'b1, 32'h1234_5678, wl, '0, 0, 2);

    // Reset asserted during a read, after two beats.
    read_i = 1'b1; address_i = 32'h0000_0ABC;
    @(negedge clk);
    resp_i = 1'b1; burst_i = 64'h5555_5555_5555_5555;
    @(negedge clk);
    burst_i = 64'h6666_6666_6666_6666;
    @(negedge clk);
    resp_i = 1'b0; read_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_read_o", read_o, 1'b0);
    chk("mid_rst_resp_o", resp_o, 1'b0);
    chk("mid_rst_line_o", line_o, '0);
    chk("mid_rst_address_o", address_o, '0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_hold_resp_o", resp_o, 1'b0);
      chk("mid_rst_hold_read_o", read_o, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_resp_o", resp_o, 1'b0);
    rl = rand_line();
    txn(1'b0, 1'b0, 32'h0000_0ABC, '0, rl, 0, 1);

    // Randomized transfers.
    for (int t = 0; t < 24; t++) begin
      txn(bit'($urandom_range(1, 0)), bit'($urandom_range(3, 0) == 0), $urandom,
          rand_line(), rand_line(), 0, 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
